serial_add_ctrl: RTL and testbench

//  Bit-serial adder controller: sequences a single 1-bit full adder over WIDTH

---
 rtl/serial_pkg.sv | 14 +
 rtl/serial_add_ctrl_fa.sv | 16 +
 rtl/serial_add_ctrl.sv | 95 +++++++++
 tb/tb_serial_add_ctrl.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pkg.sv
// Shared definitions for the bit-serial adder controller.
// Holds the controller state encoding and its width.
package serial_pkg;

    localparam int ST_W = 2;

    // Encoding 2'd3 is unused; the controller treats it like ST_IDLE.
    typedef enum logic [ST_W-1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/serial_add_ctrl_fa.sv
// One-bit full adder used as the single arithmetic element of the serial adder.
module FullAdderStructure (
    input  logic x,
    input  logic y,
    input  logic cin,
    output logic cout,
    output logic s
);

    logic half_sum;

    assign half_sum = x ^ y;
    assign s        = half_sum ^ cin;
    assign cout     = (x & y) | (cin & half_sum);

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: runs one full adder LSB-first over WIDTH cycles
// to produce {cout,sum} = a + b + cin with a start/done handshake.
module serial_add_ctrl
    import serial_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    state_t           state_reg;
    logic [WIDTH-1:0] op_a_reg;
    logic [WIDTH-1:0] op_b_reg;
    logic [WIDTH-1:0] res_reg;
    logic [WIDTH-1:0] sum_reg;
    logic [CW-1:0]    count_reg;
    logic             carry_reg;
    logic             cout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic             fa_s;
    logic             fa_cout;
    logic [WIDTH-1:0] res_next;

    FullAdderStructure u_fa (
        .x   (op_a_reg[0]),
        .y   (op_b_reg[0]),
        .cin (carry_reg),
        .cout(fa_cout),
        .s   (fa_s)
    );

    // New sum bits enter at the top so bit 0 lands in res[0] after WIDTH shifts.
    assign res_next = {fa_s, res_reg[WIDTH-1:1]};

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= ST_IDLE;
            op_a_reg  <= '0;
            op_b_reg  <= '0;
            res_reg   <= '0;
            sum_reg   <= '0;
            count_reg <= '0;
            carry_reg <= 1'b0;
            cout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (state_reg == ST_RUN) begin
                op_a_reg  <= op_a_reg >> 1;
                op_b_reg  <= op_b_reg >> 1;
                carry_reg <= fa_cout;
                res_reg   <= res_next;
                count_reg <= count_reg + 1'b1;
                if (count_reg == LAST_BIT) begin
                    state_reg <= ST_DONE;
                    busy_reg  <= 1'b0;
                    done_reg  <= 1'b1;
                    sum_reg   <= res_next;
                    cout_reg  <= fa_cout;
                end
            end else if (start) begin
                // IDLE, DONE and the unused encoding all accept a new request.
                state_reg <= ST_RUN;
                busy_reg  <= 1'b1;
                op_a_reg  <= a;
                op_b_reg  <= b;
                carry_reg <= cin;
                count_reg <= '0;
            end else begin
                state_reg <= ST_IDLE;
            end
        end
    end

    assign busy = busy_reg;
    assign done = done_reg;
    assign sum  = sum_reg;
    assign cout = cout_reg;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Self-checking bench for serial_add_ctrl: vector table, corner sequences,
// random operands against an arithmetic model, and a WIDTH=4 exhaustive sweep.
module tb_serial_add_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a, b;
    logic       cin;
    logic       busy, done, cout;
    logic [7:0] sum;

    logic       start4;
    logic [3:0] a4, b4;
    logic       cin4;
    logic       busy4, done4, cout4;
    logic [3:0] sum4;

    int checks   = 0;
    int failures = 0;

    logic [7:0] prev_sum;
    logic       prev_cout;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    serial_add_ctrl #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .a(a4), .b(b4), .cin(cin4),
        .busy(busy4), .done(done4), .sum(sum4), .cout(cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    // Reference: plain integer addition, split into sum and carry-out.
    task automatic model8(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          output logic [7:0] s, output logic c);
        int t;
        t = int'(va) + int'(vb) + int'(vc);
        s = t[7:0];
        c = t[8];
    endtask

    // One transaction: start pulse, then watch 12 cycles for handshake timing and result.
    task automatic run_op(input logic [7:0] va, input logic [7:0] vb, input logic vc,
                          input logic [7:0] exp_s, input logic exp_c,
                          input bit perturb, input string tag);
        int busy_n, done_k, done_n;
        bit held_ok, overlap;
        logic [7:0] s_got;
        logic c_got;
        s_got = 'x;
        c_got = 1'bx;
        a = va; b = vb; cin = vc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0; done_k = 0; done_n = 0; held_ok = 1; overlap = 0;
        for (int k = 1; k <= 12; k++) begin
            if (busy) busy_n++;
            if (busy && done) overlap = 1;
            if (done) begin
                done_n++;
                if (done_k == 0) begin
                    done_k = k;
                    s_got = sum;
                    c_got = cout;
                end
            end else if (done_k == 0 && (sum !== prev_sum || cout !== prev_cout)) begin
                held_ok = 0;
            end
            if (perturb && k == 3) begin
                start = 1'b1; a = 8'h00; b = 8'h00; cin = 1'b0;
            end
            if (perturb && k == 4) start = 1'b0;
            @(negedge clk);
        end
        chk({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        chk({tag, "_done_cycle"}, 32'(done_k), 32'd9);
        chk({tag, "_done_pulses"}, 32'(done_n), 32'd1);
        chk({tag, "_busy_done_overlap"}, 32'(overlap), 32'd0);
        chk({tag, "_result_held"}, 32'(held_ok), 32'd1);
        chk({tag, "_sum"}, 32'(s_got), 32'(exp_s));
        chk({tag, "_cout"}, 32'(c_got), 32'(exp_c));
        $display("op %s a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d", tag, va, vb, vc, s_got, c_got);
        prev_sum  = exp_s;
        prev_cout = exp_c;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] es;
        logic       ec;
        logic [7:0] ra, rb;
        logic       rc;
        int         idx, last_k, done_n, bad_gap;
        logic [7:0] ba[6], bb[6];
        logic       bc[6];
        logic [4:0] t4;

        vecs[0] = '{8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h7F, 8'h00, 1'b1, 8'h80, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};

        start4 = 1'b0; a4 = '0; b4 = '0; cin4 = 1'b0;

        // Reset held with start asserted: nothing may begin.
        rst = 1'b1; start = 1'b1; a = 8'h3C; b = 8'h5A; cin = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("reset_busy", 32'(busy), 32'd0);
            chk("reset_done", 32'(done), 32'd0);
            chk("reset_sum", 32'(sum), 32'd0);
            chk("reset_cout", 32'(cout), 32'd0);
        end
        rst = 1'b0; start = 1'b0;
        prev_sum = 8'h00; prev_cout = 1'b0;
        @(negedge clk);
        chk("idle_after_reset_busy", 32'(busy), 32'd0);
        $display("reset sequence done");

        foreach (vecs[i])
            run_op(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].exp_sum, vecs[i].exp_cout, 1'b0,
                   $sformatf("vec%0d", i));

        // start pulse and operand change while running must be ignored.
        run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b1, "perturb");

        // Reset in the middle of a run abandons it.
        run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, "pre_abort");
        a = 8'h3C; b = 8'h5A; cin = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_sum", 32'(sum), 32'd0);
        chk("abort_cout", 32'(cout), 32'd0);
        done_n = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done || busy) done_n++;
        end
        chk("abort_no_activity", 32'(done_n), 32'd0);
        $display("op abort: reset mid-run, sum=%02h cout=%0d", sum, cout);
        prev_sum = 8'h00; prev_cout = 1'b0;
        run_op(8'h3C, 8'h5A, 1'b0, 8'h96, 1'b0, 1'b0, "post_abort");

        // Random operands against the arithmetic model.
        for (int i = 0; i < 16; i++) begin
            ra = 8'($urandom); rb = 8'($urandom); rc = 1'($urandom);
            model8(ra, rb, rc, es, ec);
            run_op(ra, rb, rc, es, ec, 1'b0, $sformatf("rand%0d", i));
        end

        // Back-to-back with start held high; new operands presented at each done.
        for (int i = 0; i < 6; i++) begin
            ba[i] = 8'($urandom); bb[i] = 8'($urandom); bc[i] = 1'($urandom);
        end
        ba[0] = 8'hFF; bb[0] = 8'h01; bc[0] = 1'b0;
        a = ba[0]; b = bb[0]; cin = bc[0]; start = 1'b1;
        @(negedge clk);
        idx = 0; last_k = 0;
        for (int k = 1; k <= 200 && idx < 6; k++) begin
            if (done) begin
                model8(ba[idx], bb[idx], bc[idx], es, ec);
                chk($sformatf("b2b%0d_sum", idx), 32'(sum), 32'(es));
                chk($sformatf("b2b%0d_cout", idx), 32'(cout), 32'(ec));
                chk($sformatf("b2b%0d_period", idx), 32'(k - last_k), 32'd9);
                $display("op b2b%0d a=%02h b=%02h cin=%0d -> sum=%02h cout=%0d at cycle %0d",
                         idx, ba[idx], bb[idx], bc[idx], sum, cout, k);
                last_k = k;
                idx++;
                if (idx < 6) begin
                    a = ba[idx]; b = bb[idx]; cin = bc[idx];
                end else begin
                    start = 1'b0;
                end
            end
            @(negedge clk);
        end
        start = 1'b0;
        chk("b2b_results_seen", 32'(idx), 32'd6);

        // WIDTH=4 exhaustive sweep, back-to-back.
        a4 = 4'd0; b4 = 4'd0; cin4 = 1'b0; start4 = 1'b1;
        @(negedge clk);
        idx = 0; last_k = 0; bad_gap = 0;
        for (int k = 1; k <= 512 * 5 + 50 && idx < 512; k++) begin
            if (done4) begin
                t4 = 5'(int'(a4) + int'(b4) + int'(cin4));
                chk($sformatf("w4_a%0h_b%0h_c%0d", a4, b4, cin4), 32'({cout4, sum4}), 32'(t4));
                if (idx > 0 && (k - last_k) != 5) bad_gap++;
                if (idx % 64 == 0)
                    $display("op w4 #%0d a=%0h b=%0h cin=%0d -> sum=%0h cout=%0d",
                             idx, a4, b4, cin4, sum4, cout4);
                last_k = k;
                idx++;
                if (idx < 512) begin
                    a4 = 4'(idx); b4 = 4'(idx >> 4); cin4 = 1'(idx >> 8);
                end else begin
                    start4 = 1'b0;
                end
            end
            @(negedge clk);
        end
        start4 = 1'b0;
        chk("w4_results_seen", 32'(idx), 32'd512);
        chk("w4_period_errors", 32'(bad_gap), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
